// File: rtl/rv32_mem_pkg.sv
// Shared types for the RV32I data-memory path: arbiter state encoding,
// requester port indices and the per-port memory request payload.
package rv32_mem_pkg;

    localparam int unsigned NUM_PORTS   = 2;
    localparam int unsigned PORT_CPU    = 0;
    localparam int unsigned PORT_LDR    = 1;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned MASK_W      = 4;
    localparam int unsigned DMEM_ADDR_W = 14;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]      wdata;
        logic [MASK_W-1:0]      wmask;
    } mem_req_t;

endpackage

// File: rtl/rv32_arb_wait_cnt.sv
// Saturating wait counter for one arbiter port.
//   clk, rst   : clock, synchronous active-high reset
//   valid      : port is requesting this cycle
//   granted    : port is granted this cycle
//   starved_c  : port is requesting and has waited MAX_WAIT cycles
module rv32_arb_wait_cnt #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic granted,
    output logic starved_c
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] cnt;

    // Count waiting cycles; any grant or idle cycle restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!valid || granted) begin
            cnt <= '0;
        end else if (cnt != CNT_W'(MAX_WAIT)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Stale count from a withdrawn request must not force a grant.
    assign starved_c = valid && (cnt == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/rv32_dmem_arbiter.sv
// Two-port arbiter for the single-port synchronous-read DMEM.
// Port 0 = CPU load/store unit, port 1 = UART boot/hex loader.
// Build option: RV32_DMEM_ARB_RR_EN selects round-robin tie breaking;
// without it port 0 has fixed priority and starvation counters alone
// guarantee port 1 progress.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/ready      : per-port handshake, ready is one-hot or zero
//   req_we/lock/addr/wdata/wmask : per-port request payload
//   resp_valid           : per-port strobe, one cycle after the access
//   resp_rdata           : shared read data (memory read data)
//   mem_en/we/addr/wdata : memory command, driven from the granted port
//   mem_rdata            : memory read data, one cycle after mem_en
module rv32_dmem_arbiter
    import rv32_mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = DMEM_ADDR_W,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_we,
    input  logic [1:0]             req_lock,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][31:0]       req_wdata,
    input  logic [1:0][3:0]        req_wmask,
    output logic [1:0]             resp_valid,
    output logic [31:0]            resp_rdata,
    output logic                   mem_en,
    output logic [3:0]             mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [31:0]            mem_wdata,
    input  logic [31:0]            mem_rdata
);

    arb_state_e state;
    logic [1:0] grant_c;
    logic [1:0] starved_c;
    logic [1:0] tie_grant_c;
    logic [1:0] resp_valid_q;
    mem_req_t   cpu_req_c;
    mem_req_t   ldr_req_c;
    mem_req_t   sel_req_c;

    // One starvation counter per requester.
    rv32_arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait_cpu (
        .clk       (clk),
        .rst       (rst),
        .valid     (req_valid[PORT_CPU]),
        .granted   (grant_c[PORT_CPU]),
        .starved_c (starved_c[PORT_CPU])
    );

    rv32_arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait_ldr (
        .clk       (clk),
        .rst       (rst),
        .valid     (req_valid[PORT_LDR]),
        .granted   (grant_c[PORT_LDR]),
        .starved_c (starved_c[PORT_LDR])
    );

`ifdef RV32_DMEM_ARB_RR_EN
    logic last_grant;

    // Round-robin: the port that did not transfer last wins a tie.
    always_comb begin
        tie_grant_c = last_grant ? 2'b01 : 2'b10;
    end
`else
    // Fixed priority: CPU wins a tie.
    always_comb begin
        tie_grant_c = 2'b01;
    end
`endif

    // Grant selection: starvation first, then lock ownership, then policy.
    always_comb begin
        grant_c = 2'b00;
        case (state)
            LOCK0: begin
                if (starved_c[PORT_LDR])      grant_c = 2'b10;
                else if (req_valid[PORT_CPU]) grant_c = 2'b01;
            end
            LOCK1: begin
                if (starved_c[PORT_CPU])      grant_c = 2'b01;
                else if (req_valid[PORT_LDR]) grant_c = 2'b10;
            end
            default: begin
                if (req_valid == 2'b11) begin
                    if (starved_c[PORT_LDR])      grant_c = 2'b10;
                    else if (starved_c[PORT_CPU]) grant_c = 2'b01;
                    else                          grant_c = tie_grant_c;
                end else begin
                    grant_c = req_valid;
                end
            end
        endcase
        if (rst) grant_c = 2'b00;
    end

    // Pack per-port payloads and steer the granted one to memory;
    // with no grant the CPU payload is presented but not enabled.
    always_comb begin
        cpu_req_c.we    = req_we[PORT_CPU];
        cpu_req_c.addr  = DMEM_ADDR_W'(req_addr[PORT_CPU]);
        cpu_req_c.wdata = req_wdata[PORT_CPU];
        cpu_req_c.wmask = req_wmask[PORT_CPU];
        ldr_req_c.we    = req_we[PORT_LDR];
        ldr_req_c.addr  = DMEM_ADDR_W'(req_addr[PORT_LDR]);
        ldr_req_c.wdata = req_wdata[PORT_LDR];
        ldr_req_c.wmask = req_wmask[PORT_LDR];
        sel_req_c       = grant_c[PORT_LDR] ? ldr_req_c : cpu_req_c;
    end

    assign req_ready  = grant_c;
    assign mem_en     = |grant_c;
    assign mem_we     = sel_req_c.wmask & {4{sel_req_c.we & mem_en}};
    assign mem_addr   = ADDR_W'(sel_req_c.addr);
    assign mem_wdata  = sel_req_c.wdata;
    assign resp_rdata = mem_rdata;
    // Reset drops any response still in flight.
    assign resp_valid = rst ? 2'b00 : resp_valid_q;

    // Lock state, response owner and last-grant tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ARB;
            resp_valid_q <= 2'b00;
`ifdef RV32_DMEM_ARB_RR_EN
            last_grant   <= 1'b1;
`endif
        end else begin
            resp_valid_q <= grant_c;
            if (grant_c[PORT_CPU]) begin
                state <= req_lock[PORT_CPU] ? LOCK0 : ARB;
            end else if (grant_c[PORT_LDR]) begin
                state <= req_lock[PORT_LDR] ? LOCK1 : ARB;
            end else begin
                state <= ARB;
            end
`ifdef RV32_DMEM_ARB_RR_EN
            if (|grant_c) last_grant <= grant_c[PORT_LDR];
`endif
        end
    end

endmodule

// File: tb/tb_rv32_dmem_arbiter.sv
// Bench for rv32_dmem_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level reference of the arbitration rules.
module tb_rv32_dmem_arbiter;

    localparam int MW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid, req_ready, req_we, req_lock;
    logic [1:0][13:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0][3:0]  req_wmask;
    logic [1:0]       resp_valid;
    logic [31:0]      resp_rdata;
    logic             mem_en;
    logic [3:0]       mem_we;
    logic [13:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;

    rv32_dmem_arbiter #(.ADDR_W(14), .MAX_WAIT(MW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_lock   (req_lock),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural DMEM macro: byte-masked write, registered read.
    logic [31:0] tb_mem [32];
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= tb_mem[mem_addr[4:0]];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) tb_mem[mem_addr[4:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Reference state: waiting cycles, lock owner, last winner, pending response.
    int          wc [2];
    int          owner;
    int          last;
    int          pend;
    bit          pend_rd;
    logic [31:0] pend_data;
    logic [31:0] ref_mem [32];

    // Observed and expected values for the current cycle.
    logic [1:0]  obs_ready, obs_rv, exp_ready, exp_rv;
    logic        obs_en, exp_en;
    logic [3:0]  obs_we, exp_we;
    logic [13:0] obs_addr, exp_addr;
    logic [31:0] obs_wdata, exp_wdata, obs_rdata, exp_rdata;
    bit          exp_rd_chk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Sample one cycle (inputs already driven) and advance the reference.
    task automatic step();
        int g;
        bit s0, s1;
        #1;
        obs_ready = req_ready; obs_en = mem_en; obs_we = mem_we;
        obs_addr = mem_addr; obs_wdata = mem_wdata;
        obs_rv = resp_valid; obs_rdata = resp_rdata;

        exp_rv = 2'b00; exp_rd_chk = 0; exp_rdata = '0;
        if (!rst && pend >= 0) begin
            exp_rv[pend] = 1'b1; exp_rd_chk = pend_rd; exp_rdata = pend_data;
        end

        g = -1;
        s0 = req_valid[0] && (wc[0] >= MW);
        s1 = req_valid[1] && (wc[1] >= MW);
        if (!rst) begin
            if (owner >= 0) begin
                if ((owner == 0 && s1) || (owner == 1 && s0)) g = 1 - owner;
                else if (req_valid[owner]) g = owner;
            end else if (req_valid == 2'b11) begin
                if (s1) g = 1;
                else if (s0) g = 0;
                else begin
`ifdef RV32_DMEM_ARB_RR_EN
                    g = (last == 1) ? 0 : 1;
`else
                    g = 0;
`endif
                end
            end else if (req_valid[0]) g = 0;
            else if (req_valid[1]) g = 1;
        end

        exp_ready = 2'b00; exp_en = 0; exp_we = 4'h0; exp_addr = '0; exp_wdata = '0;
        if (g >= 0) begin
            exp_ready[g] = 1'b1; exp_en = 1;
            exp_we = req_we[g] ? req_wmask[g] : 4'h0;
            exp_addr = req_addr[g]; exp_wdata = req_wdata[g];
        end

        if (rst) begin
            wc[0] = 0; wc[1] = 0; owner = -1; last = 1; pend = -1;
        end else begin
            for (int i = 0; i < 2; i++)
                wc[i] = (req_valid[i] && g != i) ? ((wc[i] < MW) ? wc[i] + 1 : MW) : 0;
            pend = g;
            owner = -1;
            if (g >= 0) begin
                pend_rd = !req_we[g];
                pend_data = ref_mem[req_addr[g][4:0]];
                for (int b = 0; b < 4; b++)
                    if (exp_we[b]) ref_mem[req_addr[g][4:0]][8*b +: 8] = req_wdata[g][8*b +: 8];
                owner = req_lock[g] ? g : -1;
                last = g;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_valid = 2'b00; req_we = 2'b00; req_lock = 2'b00;
        req_addr = '0; req_wdata = '0; req_wmask = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1; step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b11; req_we = 2'b01; req_lock = 2'b11; req_wmask = '1;
        for (int c = 0; c < 2; c++) begin
            step();
            total_cnt++;
            if (obs_ready !== 2'b00 || obs_en !== 1'b0 || obs_rv !== 2'b00)
                $display("FAIL reset: ready=%b en=%b rv=%b required 00/0/00", obs_ready, obs_en, obs_rv);
            else pass_cnt++;
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    // Fill all 32 words through port 0; word 0x10 holds 0xDEADBEEF.
    task automatic test_preload();
        for (int i = 0; i < 32; i++) begin
            req_valid = 2'b01; req_we = 2'b01; req_lock = 2'b00;
            req_addr[0] = 14'(i); req_wmask[0] = 4'hF;
            req_wdata[0] = (i == 16) ? 32'hDEADBEEF : $urandom;
            step();
            total_cnt++;
            if (obs_ready !== 2'b01 || obs_we !== 4'hF)
                $display("FAIL preload[%0d]: ready=%b we=%h required 01/f", i, obs_ready, obs_we);
            else pass_cnt++;
        end
        idle_inputs();
        step();
    endtask

    task automatic test_single_read();
        req_valid = 2'b01; req_we = 2'b00; req_addr[0] = 14'h10;
        step();
        total_cnt++;
        if (obs_ready !== 2'b01 || obs_en !== 1'b1 || obs_addr !== 14'h10 || obs_we !== 4'h0)
            $display("FAIL read_grant: ready=%b en=%b addr=%h we=%h required 01/1/0010/0",
                     obs_ready, obs_en, obs_addr, obs_we);
        else pass_cnt++;
        idle_inputs();
        step();
        total_cnt++;
        if (obs_rv !== 2'b01 || obs_rdata !== 32'hDEADBEEF)
            $display("FAIL read_resp: rv=%b rdata=%h required 01/deadbeef", obs_rv, obs_rdata);
        else pass_cnt++;
    endtask

    task automatic test_starvation();
        logic [1:0] trace [10];
        logic [1:0] expv [10];
`ifdef RV32_DMEM_ARB_RR_EN
        expv = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
        expv = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
`endif
        do_reset();
        for (int c = 0; c < 10; c++) begin
            req_valid = 2'b11; req_we = 2'b00; req_lock = 2'b00;
            req_addr[0] = 14'($urandom_range(31)); req_addr[1] = 14'($urandom_range(31));
            step();
            trace[c] = obs_ready;
        end
        idle_inputs();
        for (int c = 0; c < 10; c++) begin
            total_cnt++;
            if (trace[c] !== expv[c])
                $display("FAIL starvation cycle %0d: ready=%b required %b", c, trace[c], expv[c]);
            else pass_cnt++;
        end
        step();
    endtask

    // Loader burst; CPU joins on cycle 2 and waits. With burst_len 4 the
    // burst completes; with burst_len 8 the CPU wait limit breaks the lock.
    task automatic run_burst(input int burst_len, input int cycles, output logic [1:0] trace [10]);
        int k = 0;
        bit p0_done = 0;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            req_valid[1] = (k < burst_len); req_we[1] = 1'b1;
            req_lock[1] = (k < burst_len - 1);
            req_addr[1] = 14'(20 + (k % 8)); req_wdata[1] = $urandom; req_wmask[1] = 4'hF;
            req_valid[0] = (c >= 1) && !p0_done; req_we[0] = 1'b0; req_lock[0] = 1'b0;
            req_addr[0] = 14'h5;
            step();
            trace[c] = obs_ready;
            if (obs_ready[1]) k++;
            if (obs_ready[0]) p0_done = 1;
        end
        idle_inputs();
    endtask

    task automatic test_lock_burst();
        logic [1:0] trace [10];
        logic [1:0] expv [5];
        expv = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        run_burst(4, 5, trace);
        step();
        total_cnt++;
        if (obs_rv !== 2'b01 || obs_rdata !== exp_rdata)
            $display("FAIL burst_cpu_resp: rv=%b rdata=%h required 01/%h", obs_rv, obs_rdata, exp_rdata);
        else pass_cnt++;
        for (int c = 0; c < 5; c++) begin
            total_cnt++;
            if (trace[c] !== expv[c])
                $display("FAIL lock_burst cycle %0d: ready=%b required %b", c, trace[c], expv[c]);
            else pass_cnt++;
        end
    endtask

    task automatic test_lock_break();
        logic [1:0] trace [10];
        logic [1:0] expv [10];
        expv = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00};
        run_burst(8, 10, trace);
        for (int c = 0; c < 10; c++) begin
            total_cnt++;
            if (trace[c] !== expv[c])
                $display("FAIL lock_break cycle %0d: ready=%b required %b", c, trace[c], expv[c]);
            else pass_cnt++;
        end
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 2'b01; req_we = 2'b00; req_addr[0] = 14'h10;
        step();
        rst = 1'b1; req_valid = 2'b11;
        step();
        total_cnt++;
        if (obs_rv !== 2'b00 || obs_ready !== 2'b00 || obs_en !== 1'b0 || obs_we !== 4'h0)
            $display("FAIL reset_mid: rv=%b ready=%b en=%b we=%h required 00/00/0/0",
                     obs_rv, obs_ready, obs_en, obs_we);
        else pass_cnt++;
        rst = 1'b0;
        idle_inputs();
        step();
        total_cnt++;
        if (obs_rv !== 2'b00)
            $display("FAIL reset_mid_drop: rv=%b required 00", obs_rv);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(99) == 0);
            for (int p = 0; p < 2; p++) begin
                req_valid[p] = ($urandom_range(3) != 0);
                req_lock[p]  = ($urandom_range(2) == 0);
                req_we[p]    = $urandom_range(1);
                req_addr[p]  = 14'($urandom_range(31));
                req_wdata[p] = $urandom;
                req_wmask[p] = 4'($urandom_range(15));
            end
            step();
            total_cnt++;
            if (obs_ready !== exp_ready || obs_en !== exp_en || obs_we !== exp_we)
                $display("FAIL rand_grant c%0d: ready=%b en=%b we=%h required %b/%b/%h",
                         c, obs_ready, obs_en, obs_we, exp_ready, exp_en, exp_we);
            else pass_cnt++;
            if (exp_en) begin
                total_cnt++;
                if (obs_addr !== exp_addr || obs_wdata !== exp_wdata)
                    $display("FAIL rand_mux c%0d: addr=%h wdata=%h required %h/%h",
                             c, obs_addr, obs_wdata, exp_addr, exp_wdata);
                else pass_cnt++;
            end
            total_cnt++;
            if (obs_rv !== exp_rv)
                $display("FAIL rand_resp c%0d: rv=%b required %b", c, obs_rv, exp_rv);
            else pass_cnt++;
            if (exp_rd_chk) begin
                total_cnt++;
                if (obs_rdata !== exp_rdata)
                    $display("FAIL rand_rdata c%0d: rdata=%h required %h", c, obs_rdata, exp_rdata);
                else pass_cnt++;
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        wc[0] = 0; wc[1] = 0; owner = -1; last = 1; pend = -1;
        pend_rd = 0; pend_data = '0;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_preload();
        test_single_read();
        test_starvation();
        test_lock_burst();
        test_lock_break();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
